// File: rtl/wb_arbiter_rr.sv
// ============================================================================
// Module   : wb_arbiter_rr
// Purpose  : Round-robin arbiter sharing one pipelined Wishbone slave among
//            numm masters, with outstanding-request tracking per grant.
// Option   : WB_ARB_TIMEOUT_EN enables the no-response abort timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter_rr #(
   parameter int numm    = 3,
   parameter int maxout  = 4,
   parameter int timeout = 255,
   parameter int aw      = 32,
   parameter int dw      = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [numm-1:0]             wbm_cyc,
   input  logic [numm-1:0]             wbm_stb,
   input  logic [numm-1:0]             wbm_we,
   input  logic [numm-1:0][aw-1:0]     wbm_adr,
   input  logic [numm-1:0][dw/8-1:0]   wbm_sel,
   input  logic [numm-1:0][dw-1:0]     wbm_dat_w,
   output logic [numm-1:0]             wbm_stall,
   output logic [numm-1:0]             wbm_ack,
   output logic [numm-1:0]             wbm_err,
   output logic [numm-1:0][dw-1:0]     wbm_dat_r,
   output logic                        wbs_cyc,
   output logic                        wbs_stb,
   output logic                        wbs_we,
   output logic [aw-1:0]               wbs_adr,
   output logic [dw/8-1:0]             wbs_sel,
   output logic [dw-1:0]               wbs_dat_w,
   input  logic                        wbs_stall,
   input  logic                        wbs_ack,
   input  logic                        wbs_err,
   input  logic [dw-1:0]               wbs_dat_r,
   output logic [numm-1:0]             grant
);

   localparam int iw = $clog2(numm);
   localparam int cw = $clog2(maxout + 1);

   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t              state, state_n;
   logic [iw-1:0]       ptr, ptr_n, win_idx;
   logic [cw-1:0]       cnt, cnt_n;
   logic [numm-1:0]     grant_n, win_oh, req;
   logic                win_found;
   logic                own_cyc, own_stb, own_we;
   logic [aw-1:0]       own_adr;
   logic [dw/8-1:0]     own_sel;
   logic [dw-1:0]       own_dat;
   logic                full, resp, resp_ok, live, accept, to_hit;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int tw = $clog2(timeout + 1);
   logic [tw-1:0]   timer;
   logic [numm-1:0] abort_mask;

   // timer holds (cycles since acceptance - 1), so the abort lands on the
   // timeout-th cycle after the request was accepted
   assign to_hit = (state == GRANT) && (cnt != '0) && !resp && (timer == tw'(timeout - 1));
   assign req    = wbm_cyc & ~abort_mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         timer      <= '0;
         abort_mask <= '0;
      end else begin
         timer      <= (state != GRANT || cnt == '0 || resp || to_hit) ? '0 : timer + tw'(1);
         abort_mask <= (abort_mask & wbm_cyc) | (to_hit ? grant : '0);
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (timeout < 1);
   assign to_hit     = 1'b0;
   assign req        = wbm_cyc;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= iw'(numm - 1);
         cnt   <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

   // rotating search starting just after the last winner
   always_comb begin
      int j;
      win_found = 1'b0;
      win_idx   = '0;
      win_oh    = '0;
      for (int k = 1; k <= numm; k++) begin
         j = (int'(ptr) + k) % numm;
         if (!win_found && req[j]) begin
            win_found = 1'b1;
            win_idx   = iw'(j);
            win_oh[j] = 1'b1;
         end
      end
   end

   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      own_we  = 1'b0;
      own_adr = '0;
      own_sel = '0;
      own_dat = '0;
      for (int i = 0; i < numm; i++) begin
         if (grant[i]) begin
            own_cyc = wbm_cyc[i];
            own_stb = wbm_stb[i];
            own_we  = wbm_we[i];
            own_adr = wbm_adr[i];
            own_sel = wbm_sel[i];
            own_dat = wbm_dat_w[i];
         end
      end

      full      = (cnt == cw'(maxout));
      resp      = wbs_ack | wbs_err;
      resp_ok   = (state == GRANT) && own_cyc && (cnt != '0) && resp;
      live      = (state == GRANT) && own_cyc && !to_hit;

      wbs_cyc   = live;
      wbs_stb   = live && own_stb && !full;
      wbs_we    = live && own_we;
      wbs_adr   = live ? own_adr : '0;
      wbs_sel   = live ? own_sel : '0;
      wbs_dat_w = live ? own_dat : '0;
      accept    = wbs_stb && !wbs_stall;

      for (int i = 0; i < numm; i++) begin
         wbm_stall[i] = 1'b1;
         wbm_ack[i]   = 1'b0;
         wbm_err[i]   = 1'b0;
         wbm_dat_r[i] = '0;
         if (grant[i]) begin
            wbm_stall[i] = !live || full || wbs_stall;
            wbm_ack[i]   = resp_ok && wbs_ack;
            wbm_err[i]   = (resp_ok && wbs_err) || to_hit;
            wbm_dat_r[i] = wbs_dat_r;
         end
      end

      state_n = state;
      grant_n = grant;
      ptr_n   = ptr;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (win_found) begin
               state_n = GRANT;
               grant_n = win_oh;
               ptr_n   = win_idx;
            end
         end
         GRANT: begin
            if (!own_cyc || to_hit) begin
               state_n = IDLE;
               grant_n = '0;
               cnt_n   = '0;
            end else if (accept && !resp_ok) begin
               cnt_n = cnt + cw'(1);
            end else if (!accept && resp_ok) begin
               cnt_n = cnt - cw'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_rr.sv
// ============================================================================
// Module   : tb_wb_arbiter_rr
// Purpose  : Directed self-checking bench for wb_arbiter_rr (numm=3, maxout=4);
//            the abort test runs only when WB_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter_rr;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int to_cycles = 16;
`else
   localparam int to_cycles = 255;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      cyc, stb, we;
   logic [2:0][31:0] adr, dat_w;
   logic [2:0][3:0] sel;
   logic [2:0]      wbm_stall, wbm_ack, wbm_err;
   logic [2:0][31:0] wbm_dat_r;
   logic            wbs_cyc, wbs_stb, wbs_we;
   logic [31:0]     wbs_adr, wbs_dat_w;
   logic [3:0]      wbs_sel;
   logic            s_stall, s_ack, s_err;
   logic [31:0]     s_dat;
   logic [2:0]      grant;

   typedef struct {int m; logic [31:0] d;} rsp_t;
   rsp_t       rsp_q[$];
   logic [2:0] grant_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   wb_arbiter_rr #(.numm(3), .maxout(4), .timeout(to_cycles), .aw(32), .dw(32)) dut (
      .clk(clk), .rst(rst),
      .wbm_cyc(cyc), .wbm_stb(stb), .wbm_we(we), .wbm_adr(adr), .wbm_sel(sel),
      .wbm_dat_w(dat_w), .wbm_stall(wbm_stall), .wbm_ack(wbm_ack), .wbm_err(wbm_err),
      .wbm_dat_r(wbm_dat_r),
      .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_adr(wbs_adr),
      .wbs_sel(wbs_sel), .wbs_dat_w(wbs_dat_w), .wbs_stall(s_stall), .wbs_ack(s_ack),
      .wbs_err(s_err), .wbs_dat_r(s_dat), .grant(grant)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic expect_ack(input string tag);
      rsp_t r;
      chk({tag, "_sb"}, 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) begin
         r = rsp_q.pop_front();
         chk({tag, "_vec"}, 64'(wbm_ack), 64'(3'b001 << r.m));
         chk({tag, "_dat"}, 64'(wbm_dat_r[r.m]), 64'(r.d));
      end
   endtask

   initial begin
      rst = 1'b1;
      cyc = '0; stb = '0; we = '0; adr = '0; dat_w = '0; sel = '1;
      s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dat = '0;

      // reset state
      tick(); tick(); settle();
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_cyc",   64'(wbs_cyc), 64'd0);
      chk("rst_stb",   64'(wbs_stb), 64'd0);
      chk("rst_stall", 64'(wbm_stall), 64'h7);
      chk("rst_ack",   64'(wbm_ack | wbm_err), 64'd0);
      rst = 1'b0;

      // single write from master 0
      tick();
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h10; dat_w[0] = 32'hA5A5_0001;
      settle();
      chk("t1_pre_grant", 64'(grant), 64'd0);
      chk("t1_pre_cyc",   64'(wbs_cyc), 64'd0);
      tick(); settle();
      chk("t1_grant", 64'(grant), 64'h1);
      chk("t1_cyc",   64'(wbs_cyc), 64'd1);
      chk("t1_stb",   64'(wbs_stb), 64'd1);
      chk("t1_we",    64'(wbs_we), 64'd1);
      chk("t1_adr",   64'(wbs_adr), 64'h10);
      chk("t1_dat",   64'(wbs_dat_w), 64'hA5A5_0001);
      chk("t1_stall", 64'(wbm_stall), 64'h6);
      rsp_q.push_back('{0, 32'h0000_00AA});
      tick();
      stb[0] = 1'b0; s_ack = 1'b1; s_dat = 32'h0000_00AA;
      settle();
      expect_ack("t1_ack");
      tick(); settle();
      chk("t1_stray_ack", 64'(wbm_ack), 64'd0);
      s_ack = 1'b0; cyc[0] = 1'b0;
      settle();
      chk("t1_drop_cyc", 64'(wbs_cyc), 64'd0);
      tick(); settle();
      chk("t1_idle", 64'(grant), 64'd0);

      // three simultaneous requesters, then pointer wrap
      rst = 1'b1; tick(); rst = 1'b0;
      grant_q.push_back(3'b001); grant_q.push_back(3'b010);
      grant_q.push_back(3'b100); grant_q.push_back(3'b001);
      cyc = 3'b111; stb = 3'b111; we = '0;
      for (int i = 0; i < 3; i++) adr[i] = 32'h100 + 32'(i);
      for (int m = 0; m < 3; m++) begin
         tick(); settle();
         chk("t2_grant", 64'(grant), 64'(grant_q.pop_front()));
         chk("t2_adr",   64'(wbs_adr), 64'(32'h100 + 32'(m)));
         rsp_q.push_back('{m, 32'hD0 + 32'(m)});
         tick();
         stb[m] = 1'b0; s_ack = 1'b1; s_dat = 32'hD0 + 32'(m);
         settle();
         expect_ack("t2_ack");
         tick();
         s_ack = 1'b0; cyc[m] = 1'b0;
         settle();
         chk("t2_drop_cyc", 64'(wbs_cyc), 64'd0);
         tick(); settle();
         chk("t2_idle", 64'(grant), 64'd0);
      end
      cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h200;
      tick(); settle();
      chk("t2_wrap", 64'(grant), 64'(grant_q.pop_front()));

      // outstanding limit: 5 back-to-back strobes, no acks
      for (int k = 0; k < 5; k++) begin
         chk("t3_stb",   64'(wbs_stb), 64'(k < 4));
         chk("t3_stall", 64'(wbm_stall[0]), 64'(k >= 4));
         tick(); settle();
      end
      s_ack = 1'b1; s_dat = 32'h33;
      rsp_q.push_back('{0, 32'h33});
      settle();
      expect_ack("t3_ack_full");
      chk("t3_stb_full", 64'(wbs_stb), 64'd0);
      tick();
      s_ack = 1'b0;
      settle();
      chk("t3_fifth_stb",   64'(wbs_stb), 64'd1);
      chk("t3_fifth_stall", 64'(wbm_stall), 64'h6);
      tick();
      stb[0] = 1'b0; s_ack = 1'b1; s_dat = 32'h44;
      rsp_q.push_back('{0, 32'h44}); rsp_q.push_back('{0, 32'h55});
      settle();
      expect_ack("t3_ack_a");
      tick();
      s_dat = 32'h55;
      settle();
      expect_ack("t3_ack_b");
      tick();

      // owner drops cyc with two outstanding; late ack must vanish
      s_ack = 1'b0; cyc[0] = 1'b0;
      settle();
      chk("t4_cyc_drop", 64'(wbs_cyc), 64'd0);
      chk("t4_stb_drop", 64'(wbs_stb), 64'd0);
      tick();
      s_ack = 1'b1;
      settle();
      chk("t4_grant", 64'(grant), 64'd0);
      chk("t4_late_ack", 64'(wbm_ack), 64'd0);
      tick();
      s_ack = 1'b0;

      // reset while master 1 owns the bus with three outstanding
      cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h300;
      tick(); settle();
      chk("t6_grant", 64'(grant), 64'h2);
      tick(); tick(); tick();
      stb[1] = 1'b0; rst = 1'b1;
      tick(); settle();
      chk("t6_rst_grant", 64'(grant), 64'd0);
      chk("t6_rst_cyc",   64'(wbs_cyc), 64'd0);
      chk("t6_rst_stall", 64'(wbm_stall), 64'h7);
      rst = 1'b0; cyc[0] = 1'b1; s_ack = 1'b1;
      settle();
      chk("t6_lost_ack", 64'(wbm_ack), 64'd0);
      tick();
      s_ack = 1'b0;
      settle();
      chk("t6_first", 64'(grant), 64'h1);
      cyc[1] = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
      // master 0 owns; one accepted read, slave never answers
      stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h400;
      settle();
      chk("t5_accept", 64'(wbs_stb), 64'd1);
      tick();
      stb[0] = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         settle();
         chk("t5_err", 64'(wbm_err[0]), 64'(k == 16));
         if (k == 16) chk("t5_cyc", 64'(wbs_cyc), 64'd0);
         if (k < 16) tick();
      end
      tick(); settle();
      chk("t5_idle", 64'(grant), 64'd0);
      tick(); settle();
      chk("t5_blocked", 64'(grant), 64'd0);
      cyc[0] = 1'b0;
      tick();
      cyc[0] = 1'b1;
      tick(); settle();
      chk("t5_regrant", 64'(grant), 64'h1);
`endif

      cyc = '0;
      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
